// File: rtl/mips_dbg_pkg.sv
// Shared debug-block definitions: dump FSM states and default geometry.
// Used by reg_dump_unit and its bus interface.
package mips_dbg_pkg;

  localparam int unsigned DEF_NUM_REGS = 32;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned IDX_W        = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD    = 3'd1,
    CAP   = 3'd2,
    OUT   = 3'd3,
    CKSUM = 3'd4,
    DONE  = 3'd5
  } dump_state_e;

endpackage

// File: rtl/reg_dump_unit_if.sv
// Bus bundle for reg_dump_unit: register-file read port plus the
// valid/ready dump stream.
//   master : dump unit side (drives read strobe/address and stream)
//   slave  : register file / stream consumer side
interface reg_dump_unit_if #(
  parameter int unsigned DATA_W = mips_dbg_pkg::DEF_DATA_W
);
  logic                               rf_rd_en;
  logic [mips_dbg_pkg::IDX_W-1:0]     rf_rd_addr;
  logic [DATA_W-1:0]                  rf_rd_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [mips_dbg_pkg::IDX_W-1:0]     out_index;
  logic [DATA_W-1:0]                  out_data;
  logic                               out_last;
  logic                               out_cksum;

  modport master (
    output rf_rd_en, rf_rd_addr,
    input  rf_rd_data,
    output out_valid, out_index, out_data, out_last, out_cksum,
    input  out_ready
  );

  modport slave (
    input  rf_rd_en, rf_rd_addr,
    output rf_rd_data,
    input  out_valid, out_index, out_data, out_last, out_cksum,
    output out_ready
  );
endinterface

// File: rtl/reg_dump_unit.sv
// Register dump unit: on a manual start pulse or a rising edge of the
// processor HALTED flag, reads every register-file entry in order and
// streams it out over a valid/ready port, one word per three cycles.
// Optional feature macro REG_DUMP_CKSUM_EN appends a checksum beat
// (modulo-2^DATA_W sum of all register words).
// Ports:
//   clk1   : clock, rst : synchronous active-high reset
//   halted : processor halted flag (rising edge triggers a dump)
//   start  : single-cycle manual trigger
//   busy   : dump in progress, done : one-cycle completion pulse
//   bus    : read port + stream (reg_dump_unit_if.master)
module reg_dump_unit
  import mips_dbg_pkg::*;
#(
  parameter int unsigned NUM_REGS = DEF_NUM_REGS,
  parameter int unsigned DATA_W   = DEF_DATA_W
) (
  input  logic               clk1,
  input  logic               rst,
  input  logic               halted,
  input  logic               start,
  output logic               busy,
  output logic               done,
  reg_dump_unit_if.master    bus
);

  dump_state_e      state, state_n;
  logic [IDX_W-1:0] index;
  logic             halted_q;
  logic             trig;
  logic             accept;
  logic             last_idx;
`ifdef REG_DUMP_CKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  assign trig     = start | (halted & ~halted_q);
  assign accept   = bus.out_valid & bus.out_ready;
  assign last_idx = (index == IDX_W'(NUM_REGS - 1));

  // State register
  always_ff @(posedge clk1) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (trig) state_n = RD;
      RD:   state_n = CAP;
      CAP:  state_n = OUT;
      OUT: begin
        if (accept) begin
          if (!last_idx) state_n = RD;
`ifdef REG_DUMP_CKSUM_EN
          else           state_n = CKSUM;
`else
          else           state_n = DONE;
`endif
        end
      end
`ifdef REG_DUMP_CKSUM_EN
      CKSUM: if (accept) state_n = DONE;
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath and registered outputs; strobes follow the next state so
  // they line up with the state they belong to.
  always_ff @(posedge clk1) begin
    if (rst) begin
      halted_q       <= halted;
      index          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      bus.rf_rd_en   <= 1'b0;
      bus.rf_rd_addr <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_index  <= '0;
      bus.out_data   <= '0;
      bus.out_last   <= 1'b0;
`ifdef REG_DUMP_CKSUM_EN
      bus.out_cksum  <= 1'b0;
      sum            <= '0;
`endif
    end else begin
      halted_q     <= halted;
      bus.rf_rd_en <= (state_n == RD);
      busy         <= (state_n != IDLE) && (state_n != DONE);
      done         <= (state_n == DONE);
      unique case (state)
        IDLE: begin
          if (trig) begin
            index          <= '0;
            bus.rf_rd_addr <= '0;
`ifdef REG_DUMP_CKSUM_EN
            sum            <= '0;
`endif
          end
        end
        CAP: begin
          bus.out_data  <= bus.rf_rd_data;
          bus.out_index <= index;
          bus.out_valid <= 1'b1;
`ifdef REG_DUMP_CKSUM_EN
          bus.out_last  <= 1'b0;
`else
          bus.out_last  <= last_idx;
`endif
        end
        OUT: begin
          if (accept) begin
`ifdef REG_DUMP_CKSUM_EN
            sum <= sum + bus.out_data;
`endif
            if (!last_idx) begin
              index          <= index + IDX_W'(1);
              bus.rf_rd_addr <= index + IDX_W'(1);
              bus.out_valid  <= 1'b0;
              bus.out_last   <= 1'b0;
            end else begin
`ifdef REG_DUMP_CKSUM_EN
              // Checksum beat includes the word being accepted now.
              bus.out_data  <= sum + bus.out_data;
              bus.out_index <= '0;
              bus.out_cksum <= 1'b1;
              bus.out_last  <= 1'b1;
`else
              bus.out_valid <= 1'b0;
              bus.out_last  <= 1'b0;
`endif
            end
          end
        end
`ifdef REG_DUMP_CKSUM_EN
        CKSUM: begin
          if (accept) begin
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
            bus.out_cksum <= 1'b0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef REG_DUMP_CKSUM_EN
  assign bus.out_cksum = 1'b0;
`endif

endmodule

// File: tb/tb_reg_dump_unit.sv
// Directed bench for reg_dump_unit with an expected-beat scoreboard.
module tb_reg_dump_unit;

  localparam int unsigned NR = 32;

  typedef struct {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        ck;
  } beat_t;

  logic clk1 = 1'b0;
  logic rst, halted, start, busy, done;
  reg_dump_unit_if bus ();

  reg_dump_unit dut (
    .clk1   (clk1),
    .rst    (rst),
    .halted (halted),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .bus    (bus)
  );

  always #5 clk1 = ~clk1;

  logic [31:0] mem [NR];
  beat_t       q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          rd_cnt = 0;
  int          acc_cyc [NR];
  logic        hold_pend = 1'b0;
  logic [4:0]  held_idx;
  logic [31:0] held_data;
  logic        held_last;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Register-file model: one-cycle read latency.
  always @(posedge clk1) begin
    cyc <= cyc + 1;
    if (bus.rf_rd_en) bus.rf_rd_data <= mem[bus.rf_rd_addr];
  end

  // Stream monitor: pops and compares on every accepted beat.
  always @(negedge clk1) begin
    if (done) begin
      done_cnt++;
      chk("busy_at_done", busy, 0);
    end
    if (bus.rf_rd_en) rd_cnt++;
    if (bus.out_valid) begin
      if (hold_pend) begin
        chk("hold_idx", bus.out_index, held_idx);
        chk("hold_data", bus.out_data, held_data);
        chk("hold_last", bus.out_last, held_last);
      end
      if (bus.out_ready) begin
        hold_pend = 1'b0;
        if (q.size() == 0) begin
          chk("unexpected_beat", q.size(), 1);
        end else begin
          beat_t e;
          e = q.pop_front();
          chk("beat_idx", bus.out_index, e.idx);
          chk("beat_data", bus.out_data, e.data);
          chk("beat_last", bus.out_last, e.last);
          chk("beat_cksum", bus.out_cksum, e.ck);
          if (!e.ck) acc_cyc[e.idx] = cyc;
        end
      end else begin
        hold_pend = 1'b1;
        held_idx  = bus.out_index;
        held_data = bus.out_data;
        held_last = bus.out_last;
      end
    end else begin
      hold_pend = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic push_dump();
    logic [31:0] s;
    beat_t b;
    s = '0;
    for (int k = 0; k < int'(NR); k++) begin
      b.idx  = 5'(k);
      b.data = mem[k];
      b.ck   = 1'b0;
`ifdef REG_DUMP_CKSUM_EN
      b.last = 1'b0;
`else
      b.last = (k == int'(NR) - 1);
`endif
      s = s + mem[k];
      q.push_back(b);
    end
`ifdef REG_DUMP_CKSUM_EN
    b.idx = '0; b.data = s; b.last = 1'b1; b.ck = 1'b1;
    q.push_back(b);
`endif
  endtask

  task automatic wait_done(input string tag);
    int n0;
    int n;
    n0 = done_cnt;
    n = 0;
    while (done_cnt == n0 && n < 1000) begin
      step();
      n++;
    end
    chk(tag, done_cnt - n0, 1);
  endtask

  task automatic wait_beat(input logic [4:0] k, input string tag);
    int n;
    n = 0;
    while (!(bus.out_valid && bus.out_index == k) && n < 500) begin
      step();
      n++;
    end
    chk(tag, bus.out_index, k);
  endtask

  initial begin
    int d0;
    rst = 1'b1; halted = 1'b1; start = 1'b0; bus.out_ready = 1'b0;
    for (int k = 0; k < int'(NR); k++) mem[k] = 32'(k);
    repeat (3) step();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rden", bus.rf_rd_en, 0);

    // halted already high across reset release: no dump
    rst = 1'b0;
    repeat (6) step();
    chk("no_trig_after_rst", busy, 0);
    chk("no_valid_after_rst", bus.out_valid, 0);
    halted = 1'b0;
    step();

    // Full dump of reg[k]=k on halted edge, with latency checks
    bus.out_ready = 1'b1;
    rd_cnt = 0;
    push_dump();
    halted = 1'b1;
    step();
    chk("lat_rd_en", bus.rf_rd_en, 1);
    chk("lat_rd_addr", bus.rf_rd_addr, 0);
    chk("lat_busy", busy, 1);
    chk("lat_valid0", bus.out_valid, 0);
    step();
    chk("lat_rd_en_off", bus.rf_rd_en, 0);
    chk("lat_valid1", bus.out_valid, 0);
    step();
    chk("lat_valid2", bus.out_valid, 1);
    wait_done("dump1_done");
    chk("dump1_drain", q.size(), 0);
    chk("dump1_reads", rd_cnt, NR);
    chk("throughput", acc_cyc[NR-1] - acc_cyc[0], 3 * (NR - 1));
    step();
    chk("idle_after_done", busy, 0);

    // Program results in R1..R5, halted re-rises
    halted = 1'b0;
    step();
    for (int k = 0; k < int'(NR); k++) mem[k] = 32'(k * 7 + 100);
    mem[0] = 0; mem[1] = 10; mem[2] = 20; mem[3] = 25; mem[4] = 30; mem[5] = 55;
    push_dump();
    halted = 1'b1;
    step();
    wait_done("dump2_done");
    chk("dump2_drain", q.size(), 0);

    // Backpressure on beat 3 for 5 cycles
    for (int k = 0; k < int'(NR); k++) mem[k] = 32'hA5000000 + 32'(k);
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_beat(5'd3, "bp_reach3");
    bus.out_ready = 1'b0;
    repeat (5) step();
    chk("bp_still_valid", bus.out_valid, 1);
    chk("bp_still_idx", bus.out_index, 3);
    bus.out_ready = 1'b1;
    wait_done("dump3_done");
    chk("dump3_drain", q.size(), 0);

    // Reset during beat 10 abandons the dump
    for (int k = 0; k < int'(NR); k++) mem[k] = 32'(k) ^ 32'h5A5A0000;
    push_dump();
    d0 = done_cnt;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_beat(5'd10, "rst_reach10");
    rst = 1'b1;
    bus.out_ready = 1'b0;
    step();
    chk("midrst_valid", bus.out_valid, 0);
    chk("midrst_busy", busy, 0);
    q.delete();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    repeat (10) step();
    chk("midrst_no_done", done_cnt - d0, 0);
    chk("midrst_no_valid", bus.out_valid, 0);
    rd_cnt = 0;
    push_dump();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("restart_done");
    chk("restart_drain", q.size(), 0);
    chk("restart_reads", rd_cnt, NR);

    // Start while busy and halted held high: exactly one dump
    halted = 1'b0;
    step();
    for (int k = 0; k < int'(NR); k++) mem[k] = 32'hFFFFFFF0 + 32'(k);
    push_dump();
    d0 = done_cnt;
    halted = 1'b1;
    step();
    repeat (7) step();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (20) step();
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done("dump5_done");
    repeat (40) step();
    chk("one_dump_only", done_cnt - d0, 1);
    chk("dump5_drain", q.size(), 0);
    chk("final_idle", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
